// File: rtl/battleship_turn_ctrl.sv
// Battleship game-state engine: boards, ship counts, cursor, turn and win detection.
// Optional TURN_TIMEOUT_EN adds an idle counter that forces a turn pass in AIM.
module battleship_turn_ctrl #(
    parameter int unsigned GRID_DIM   = 10,
    parameter int unsigned CELL_W     = 3,
    parameter int unsigned BOARD_SIZE = GRID_DIM * GRID_DIM * CELL_W
`ifdef TURN_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BOARD_SIZE-1:0] p1_layout,
    input  logic [BOARD_SIZE-1:0] p2_layout,
    input  logic                  btn_u,
    input  logic                  btn_d,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic                  btn_c,
    output logic [BOARD_SIZE-1:0] p1_board,
    output logic [BOARD_SIZE-1:0] p2_board,
    output logic [2:0]            p1_ships,
    output logic [2:0]            p2_ships,
    output logic [3:0]            cursor_x,
    output logic [3:0]            cursor_y,
    output logic                  turn,
    output logic                  game_over,
    output logic [1:0]            winner
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_AIM     = 3'd2;
    localparam logic [2:0] S_FIRE    = 3'd3;
    localparam logic [2:0] S_RESOLVE = 3'd4;
    localparam logic [2:0] S_OVER    = 3'd5;

    localparam logic [3:0]        MAX_POS   = 4'(GRID_DIM - 1);
    localparam logic [CELL_W-1:0] CODE_MISS = CELL_W'(6);
    localparam logic [CELL_W-1:0] CODE_HIT  = CELL_W'(7);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [5:0]        btn_now;
    logic [5:0]        btn_q;
    logic [5:0]        btn_rise;
    logic              load_rise;
    logic              c_rise;
    logic              u_rise;
    logic              d_rise;
    logic              l_rise;
    logic              r_rise;
    logic [6:0]        cur_idx;
    logic [CELL_W-1:0] opp_cell;
    logic [CELL_W-1:0] shot_code;
    logic [6:0]        shot_idx;
    logic [4:0][2:0]   p1_hits;
    logic [4:0][2:0]   p2_hits;
    logic              is_ship;
    logic [2:0]        shot_ship;
    logic [2:0]        tgt_hits;
    logic [2:0]        opp_ships;
    logic              sunk;
    logic              last_ship;
`ifdef TURN_TIMEOUT_EN
    logic [31:0]       idle_cnt;
`endif

    function automatic logic [2:0] ship_len(input logic [CELL_W-1:0] id);
        case (id)
            CELL_W'(1): ship_len = 3'd5;
            CELL_W'(2): ship_len = 3'd4;
            CELL_W'(3): ship_len = 3'd3;
            CELL_W'(4): ship_len = 3'd3;
            CELL_W'(5): ship_len = 3'd2;
            default:    ship_len = 3'd0;
        endcase
    endfunction

    // Rising-edge detection against one registered copy of every button
    assign btn_now   = {load, btn_c, btn_u, btn_d, btn_l, btn_r};
    assign btn_rise  = btn_now & ~btn_q;
    assign load_rise = btn_rise[5];
    assign c_rise    = btn_rise[4];
    assign u_rise    = btn_rise[3];
    assign d_rise    = btn_rise[2];
    assign l_rise    = btn_rise[1];
    assign r_rise    = btn_rise[0];

    assign cur_idx  = 7'(cursor_y * GRID_DIM + cursor_x);
    assign opp_cell = turn ? p1_board[CELL_W*cur_idx +: CELL_W]
                           : p2_board[CELL_W*cur_idx +: CELL_W];

    // Shot outcome; the target fleet belongs to the player not on turn
    always_comb begin
        is_ship   = (shot_code >= CELL_W'(1)) && (shot_code <= CELL_W'(5));
        shot_ship = is_ship ? 3'(shot_code - CELL_W'(1)) : 3'd0;
        tgt_hits  = turn ? p1_hits[shot_ship] : p2_hits[shot_ship];
        opp_ships = turn ? p1_ships : p2_ships;
        sunk      = is_ship && (3'(tgt_hits + 3'd1) == ship_len(shot_code));
        last_ship = sunk && (opp_ships == 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_rise) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_LOAD:    state_next = S_AIM;
                S_AIM:     if (c_rise) state_next = S_FIRE;
                S_FIRE:    state_next = S_RESOLVE;
                S_RESOLVE: state_next = last_ship ? S_OVER : S_AIM;
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= '0;
            p1_board  <= '0;
            p2_board  <= '0;
            p1_ships  <= 3'd5;
            p2_ships  <= 3'd5;
            p1_hits   <= '0;
            p2_hits   <= '0;
            cursor_x  <= 4'd0;
            cursor_y  <= 4'd0;
            turn      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'd0;
            shot_code <= '0;
            shot_idx  <= 7'd0;
`ifdef TURN_TIMEOUT_EN
            idle_cnt  <= 32'd0;
`endif
        end else begin
            btn_q     <= btn_now;
            game_over <= (state_next == S_OVER);
`ifdef TURN_TIMEOUT_EN
            if (state != S_AIM) begin
                idle_cnt <= 32'd0;
            end
`endif
            // A load edge pre-empts every other action in the same cycle
            if (!load_rise) begin
                case (state)
                    S_LOAD: begin
                        p1_board <= p1_layout;
                        p2_board <= p2_layout;
                        p1_ships <= 3'd5;
                        p2_ships <= 3'd5;
                        p1_hits  <= '0;
                        p2_hits  <= '0;
                        cursor_x <= 4'd0;
                        cursor_y <= 4'd0;
                        turn     <= 1'b0;
                        winner   <= 2'd0;
                    end
                    S_AIM: begin
                        if (c_rise) begin
                        end else if (u_rise) begin
                            if (cursor_y != 4'd0) cursor_y <= cursor_y - 4'd1;
                        end else if (d_rise) begin
                            if (cursor_y != MAX_POS) cursor_y <= cursor_y + 4'd1;
                        end else if (l_rise) begin
                            if (cursor_x != 4'd0) cursor_x <= cursor_x - 4'd1;
                        end else if (r_rise) begin
                            if (cursor_x != MAX_POS) cursor_x <= cursor_x + 4'd1;
                        end
`ifdef TURN_TIMEOUT_EN
                        if (|btn_rise[4:0]) begin
                            idle_cnt <= 32'd0;
                        end else if (idle_cnt == TIMEOUT_CYC - 32'd1) begin
                            idle_cnt <= 32'd0;
                            turn     <= ~turn;
                            cursor_x <= 4'd0;
                            cursor_y <= 4'd0;
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
`endif
                    end
                    S_FIRE: begin
                        shot_code <= opp_cell;
                        shot_idx  <= cur_idx;
                    end
                    S_RESOLVE: begin
                        // Codes 6/7 are repeat shots: nothing changes
                        if (shot_code == CELL_W'(0)) begin
                            if (turn) p1_board[CELL_W*shot_idx +: CELL_W] <= CODE_MISS;
                            else      p2_board[CELL_W*shot_idx +: CELL_W] <= CODE_MISS;
                            turn <= ~turn;
                        end else if (is_ship) begin
                            if (turn) begin
                                p1_board[CELL_W*shot_idx +: CELL_W] <= CODE_HIT;
                                p1_hits[shot_ship] <= p1_hits[shot_ship] + 3'd1;
                                if (sunk) p1_ships <= p1_ships - 3'd1;
                            end else begin
                                p2_board[CELL_W*shot_idx +: CELL_W] <= CODE_HIT;
                                p2_hits[shot_ship] <= p2_hits[shot_ship] + 3'd1;
                                if (sunk) p2_ships <= p2_ships - 3'd1;
                            end
                            if (last_ship) begin
                                winner <= turn ? 2'd2 : 2'd1;
                            end else begin
                                turn <= ~turn;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
